sm_seq_multiplier: RTL and testbench
====================================

SM_SEQ_MULTIPLIER -- requirements
Module: sm_seq_multiplier

Interface
REQ-001 SHALL have parameter MAG_W, default 8: magnitude width of each operand, legal range 2..32.
REQ-002 SHALL have parameter ZERO_POS, default 1: when 1, a zero-magnitude product is output with sign 0; when 0, sign is always a[MAG_W]^b[MAG_W].
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request a multiply, sampled in IDLE only.
REQ-006 SHALL have port a, input, MAG_W+1 bits: sign-magnitude operand, bit MAG_W is the sign (1 = negative), sampled with start.
REQ-007 SHALL have port b, input, MAG_W+1 bits: sign-magnitude operand, same format, sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-009 SHALL have port prdct, output, 2*MAG_W+1 bits: sign-magnitude product, bit 2*MAG_W is the sign, registered.
REQ-010 SHALL have port rdy, output, 1 bit: one-cycle pulse marking prdct valid for the new result.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 IDLE: on a rising edge with start=1, SHALL latch |a|, |b| and sign = a[MAG_W]^b[MAG_W], clear the accumulator and counter, and go to CALC.
REQ-013 CALC: each cycle SHALL perform one radix-2 shift-add step (if the current multiplier LSB = 1, add the multiplicand to the accumulator upper half; then shift right by one), increment the counter, and go to DONE after exactly MAG_W steps.
REQ-014 Accumulator SHALL be 2*MAG_W+1 bits internally so the add carry is never lost; final magnitude SHALL equal |a|*|b| exactly, with no truncation or saturation.
REQ-015 DONE: SHALL load prdct = {sign_out, magnitude}, pulse rdy for exactly one cycle, and return to IDLE on the next edge.
REQ-016 sign_out SHALL be 0 when the magnitude is 0 and ZERO_POS=1; otherwise it SHALL be the latched sign.
REQ-017 Latency: rdy SHALL be high in the cycle following the (MAG_W+1)th rising edge after the edge that sampled start; a new start is accepted on the edge after rdy.
REQ-018 start while busy=1, including the DONE cycle, SHALL be ignored, with no effect on the current operation or on any later result.
REQ-019 a and b changing while busy SHALL NOT affect the in-flight result.
REQ-020 prdct SHALL hold its last value in IDLE and CALC until overwritten in DONE.
REQ-021 Back-to-back operations SHALL be spaced MAG_W+2 cycles, start edge to start edge, minimum.

Reset
REQ-022 While rst_n=0, regardless of clk: state=IDLE, busy=0, rdy=0, prdct=0, accumulator and counter cleared.
REQ-023 Reset asserted mid-CALC or in DONE SHALL abort the operation with no rdy pulse; the first edge after release SHALL behave as IDLE.

Verification (MAG_W=8 unless stated)
REQ-024 a=9'h1FF (-255), b=9'h0FF (+255), start one cycle -> rdy after 9 edges, prdct=17'h1FE01, busy high for 9 cycles then low.
REQ-025 a=9'h100 (-0), b=9'h005 -> prdct=17'h00000 with ZERO_POS=1; with ZERO_POS=0 -> prdct=17'h10000.
REQ-026 start (3x5) then start held high through busy with a=9'h0FF -> single rdy, prdct=17'h0000F; next start accepted only after return to IDLE.
REQ-027 rst_n pulsed low on the 4th CALC cycle -> busy=0, no rdy, prdct=0; a new start of 2x2 afterwards -> prdct=17'h00004 at nominal latency.
REQ-028 MAG_W=4, a=5'h17 (-7), b=5'h19 (-9) -> rdy after 5 edges, prdct=9'h03F.
REQ-029 Random sweep of sign/magnitude pairs at MAG_W=8 and MAG_W=16 checked against a reference model; exactly one rdy per accepted start.

Source files
------------

// File: rtl/sm_seq_multiplier.sv
// Sequential sign-magnitude multiplier: one radix-2 shift-add step per cycle,
// IDLE -> CALC (MAG_W steps) -> DONE, registered product with a one-cycle rdy pulse.
module sm_seq_multiplier #(
  parameter int MAG_W    = 8,
  parameter int ZERO_POS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAG_W:0]     a,
  input  logic [MAG_W:0]     b,
  output logic               busy,
  output logic [2*MAG_W:0]   prdct,
  output logic               rdy
);

  localparam int CW = $clog2(MAG_W + 1);
  localparam int PW = 2 * MAG_W + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [MAG_W-1:0]   mcand;
  logic [PW-1:0]      acc;
  logic [CW-1:0]      cnt;
  logic               sign;
  logic               last_step;
  logic [MAG_W:0]     sum;
  logic [2*MAG_W-1:0] mag;
  logic               sign_out;

  assign last_step = (cnt == CW'(MAG_W - 1));
  // Upper half plus multiplicand; the extra bit keeps the carry of the add.
  assign sum       = acc[PW-1:MAG_W] + {1'b0, mcand};
  assign mag       = acc[2*MAG_W-1:0];
  assign sign_out  = ((ZERO_POS != 0) && (mag == '0)) ? 1'b0 : sign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      prdct <= '0;
      rdy   <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand <= a[MAG_W-1:0];
          acc   <= {{(MAG_W+1){1'b0}}, b[MAG_W-1:0]};
          cnt   <= '0;
          sign  <= a[MAG_W] ^ b[MAG_W];
        end
        CALC: begin
          // Multiplier sits in the low half and is consumed LSB first.
          if (acc[0]) acc <= {1'b0, sum, acc[MAG_W-1:1]};
          else        acc <= {1'b0, acc[PW-1:1]};
          cnt <= cnt + CW'(1);
        end
        DONE: begin
          prdct <= {sign_out, mag};
          rdy   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_seq_multiplier.sv
// Bench for sm_seq_multiplier: four parameterisations driven by directed and
// random operations, checked against an arithmetic sign-magnitude model.
module tb_sm_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [32:0] a_v [4];
  logic [32:0] b_v [4];
  logic [3:0]  busy_v;
  logic [3:0]  rdy_v;
  logic [16:0] p0;
  logic [16:0] p1;
  logic [8:0]  p2;
  logic [32:0] p3;

  int n_checks;
  int n_fail;
  logic [32:0] exp_q[$];
  logic [32:0] last_p [4];

  sm_seq_multiplier #(.MAG_W(8), .ZERO_POS(1)) d0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][8:0]), .b(b_v[0][8:0]),
    .busy(busy_v[0]), .prdct(p0), .rdy(rdy_v[0]));
  sm_seq_multiplier #(.MAG_W(8), .ZERO_POS(0)) d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][8:0]), .b(b_v[1][8:0]),
    .busy(busy_v[1]), .prdct(p1), .rdy(rdy_v[1]));
  sm_seq_multiplier #(.MAG_W(4), .ZERO_POS(1)) d2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2][4:0]), .b(b_v[2][4:0]),
    .busy(busy_v[2]), .prdct(p2), .rdy(rdy_v[2]));
  sm_seq_multiplier #(.MAG_W(16), .ZERO_POS(1)) d3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a_v[3][16:0]), .b(b_v[3][16:0]),
    .busy(busy_v[3]), .prdct(p3), .rdy(rdy_v[3]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(input int k);
    case (k)
      2:       return 4;
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic logic [32:0] prdct_of(input int k);
    case (k)
      0:       return {16'b0, p0};
      1:       return {16'b0, p1};
      2:       return {24'b0, p2};
      default: return p3;
    endcase
  endfunction

  // Reference: |a|*|b| with plain arithmetic, sign rule from ZERO_POS.
  function automatic logic [32:0] ref_prod(input int k, input logic [32:0] av, input logic [32:0] bv);
    int              w;
    longint unsigned ma, mb, mag;
    logic            s;
    logic [32:0]     r;
    w   = wof(k);
    ma  = longint'(av) & ((64'd1 << w) - 1);
    mb  = longint'(bv) & ((64'd1 << w) - 1);
    mag = ma * mb;
    s   = av[w] ^ bv[w];
    if (mag == 0 && k != 1) s = 1'b0;
    r      = 33'(mag);
    r[2*w] = s;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int k, input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk($sformatf("%s_busy%0d", tag, i), 33'(busy_v[k]), 33'(0));
      chk($sformatf("%s_rdy%0d", tag, i), 33'(rdy_v[k]), 33'(0));
    end
  endtask

  // One operation; hold keeps start high while busy, scramble changes a/b in flight.
  task automatic run_op(input int k, input logic [32:0] av, input logic [32:0] bv,
                        input bit hold, input bit scramble, input string tag);
    int          w;
    logic [32:0] e;
    w = wof(k);
    @(negedge clk);
    a_v[k] = av;
    b_v[k] = bv;
    start_v[k] = 1'b1;
    exp_q.push_back(ref_prod(k, av, bv));
    @(posedge clk);
    for (int n = 0; n <= w + 1; n++) begin
      @(negedge clk);
      if (!hold || n == w + 1) start_v[k] = 1'b0;
      if (hold) a_v[k] = 33'h0FF;
      if (scramble) begin
        a_v[k] = {1'($urandom_range(0, 1)), 32'($urandom)};
        b_v[k] = {1'($urandom_range(0, 1)), 32'($urandom)};
      end
      chk($sformatf("%s_busy_c%0d", tag, n), 33'(busy_v[k]), 33'(n <= w));
      chk($sformatf("%s_rdy_c%0d", tag, n), 33'(rdy_v[k]), 33'(n == w + 1));
      if (n <= w) begin
        chk($sformatf("%s_hold_c%0d", tag, n), prdct_of(k), last_p[k]);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s_prdct", tag), prdct_of(k), e);
        last_p[k] = e;
      end
    end
    start_v[k] = 1'b0;
  endtask

  function automatic logic [32:0] rand_op(input int k);
    logic [32:0] v;
    int          w;
    w = wof(k);
    v = {1'($urandom_range(0, 1)), 32'($urandom)};
    case ($urandom_range(0, 5))
      0: v = v & ~((33'd1 << w) - 33'd1);
      1: v = v | ((33'd1 << w) - 33'd1);
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start_v  = '0;
    for (int k = 0; k < 4; k++) begin
      a_v[k] = '0;
      b_v[k] = '0;
      last_p[k] = '0;
    end

    // reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_busy%0d", k), 33'(busy_v[k]), 33'(0));
      chk($sformatf("rst_rdy%0d", k), 33'(rdy_v[k]), 33'(0));
      chk($sformatf("rst_prdct%0d", k), prdct_of(k), 33'(0));
    end
    rst_n = 1'b1;

    // directed cases
    run_op(0, 33'h1FF, 33'h0FF, 1'b0, 1'b0, "neg255x255");
    chk("neg255x255_const", last_p[0], 33'h1FE01);
    idle_check(0, 2, "after_255");
    run_op(0, 33'h100, 33'h005, 1'b0, 1'b0, "negzero_zp1");
    run_op(1, 33'h100, 33'h005, 1'b0, 1'b0, "negzero_zp0");
    chk("negzero_zp0_const", last_p[1], 33'h10000);
    run_op(0, 33'h003, 33'h005, 1'b1, 1'b0, "start_held");
    idle_check(0, 3, "after_held");
    run_op(2, 33'h17, 33'h19, 1'b0, 1'b0, "w4_neg7xneg9");
    chk("w4_const", last_p[2], 33'h03F);
    run_op(0, 33'h1A5, 33'h03C, 1'b0, 1'b1, "scramble");

    // reset during the 4th CALC cycle
    @(negedge clk);
    a_v[0] = 33'h003;
    b_v[0] = 33'h005;
    start_v[0] = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 33'(busy_v[0]), 33'(0));
    chk("abort_rdy", 33'(rdy_v[0]), 33'(0));
    chk("abort_prdct", prdct_of(0), 33'(0));
    for (int k = 0; k < 4; k++) last_p[k] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(0, 11, "after_abort");
    run_op(0, 33'h002, 33'h002, 1'b0, 1'b0, "post_abort_2x2");
    chk("post_abort_const", last_p[0], 33'h00004);

    // random sweep at 8 and 16 bits
    for (int i = 0; i < 20; i++) begin
      run_op(0, rand_op(0), rand_op(0), 1'b0, 1'($urandom_range(0, 1)), $sformatf("rnd8_%0d", i));
      run_op(3, rand_op(3), rand_op(3), 1'b0, 1'($urandom_range(0, 1)), $sformatf("rnd16_%0d", i));
      run_op(1, rand_op(1), rand_op(1), 1'b0, 1'b0, $sformatf("rnd8z_%0d", i));
    end
    chk("queue_empty", 33'(exp_q.size()), 33'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
